// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file writeback arbiter.
//   XLEN     - data width of a writeback
//   NREG     - architectural register count
//   AW       - register address width
//   wb_src_e - identifies a writeback source (pipeline P or long-latency L)
package rf_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef enum logic {
    WB_P = 1'b0,
    WB_L = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register, marking registers that
// have an outstanding long-latency result. Register 0 is never busy.
// Ports:
//   i_clk, i_rst           - clock, asynchronous active-high reset
//   i_set, i_set_addr      - mark a register busy (wins over a same-cycle clear)
//   i_clr, i_clr_addr      - mark a register no longer busy
//   i_rs1, i_rs2, i_rd     - lookup addresses
//   o_busy_rs1/rs2/rd      - combinational busy state of each lookup address
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic [AW-1:0] i_rd,
  output logic          o_busy_rs1,
  output logic          o_busy_rs2,
  output logic          o_busy_rd
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_d;

  // Clear first, then set, so a same-cycle set of the same register survives.
  always_comb begin
    w_busy_d = r_busy;
    if (i_clr) w_busy_d[i_clr_addr] = 1'b0;
    if (i_set) w_busy_d[i_set_addr] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign o_busy_rs1 = r_busy[i_rs1];
  assign o_busy_rs2 = r_busy[i_rs2];
  assign o_busy_rd  = r_busy[i_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between the pipeline
// writeback stage (P) and the long-latency unit (L) with round-robin
// arbitration, registers the selected write, and tells decode when an issuing
// instruction must stall on a busy or in-flight register.
// Ports:
//   i_clk, i_rst                          - clock, asynchronous active-high reset
//   i_iss_valid, i_iss_long               - decode issue, completes through L
//   i_iss_rs1, i_iss_rs2, i_iss_rd        - decode operands
//   o_iss_hazard                          - combinational stall request
//   i_p_valid, o_p_ready, i_p_rd, i_p_data - pipeline writeback handshake
//   i_l_valid, o_l_ready, i_l_rd, i_l_data - long-unit writeback handshake
//   o_rf_we, o_rf_waddr, o_rf_wdata       - registered register file write port
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_iss_valid,
  input  logic            i_iss_long,
  input  logic [AW-1:0]   i_iss_rs1,
  input  logic [AW-1:0]   i_iss_rs2,
  input  logic [AW-1:0]   i_iss_rd,
  output logic            o_iss_hazard,
  input  logic            i_p_valid,
  output logic            o_p_ready,
  input  logic [AW-1:0]   i_p_rd,
  input  logic [XLEN-1:0] i_p_data,
  input  logic            i_l_valid,
  output logic            o_l_ready,
  input  logic [AW-1:0]   i_l_rd,
  input  logic [XLEN-1:0] i_l_data,
  output logic            o_rf_we,
  output logic [AW-1:0]   o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata
);

  wb_src_e         r_last;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;

  logic            w_p_ready;
  logic            w_l_ready;
  logic            w_p_xfer;
  logic            w_l_xfer;
  logic            w_xfer;
  logic [AW-1:0]   w_wb_rd;
  logic [XLEN-1:0] w_wb_data;
  logic            w_busy_rs1;
  logic            w_busy_rs2;
  logic            w_busy_rd;
  logic            w_inflight;
  logic            w_hazard;
  logic            w_sb_set;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    w_p_ready = 1'b0;
    w_l_ready = 1'b0;
    if (i_p_valid && i_l_valid) begin
      if (r_last == WB_L) w_p_ready = 1'b1;
      else                w_l_ready = 1'b1;
    end else begin
      w_p_ready = i_p_valid;
      w_l_ready = i_l_valid;
    end
  end

  assign w_p_xfer  = i_p_valid & w_p_ready;
  assign w_l_xfer  = i_l_valid & w_l_ready;
  assign w_xfer    = w_p_xfer | w_l_xfer;
  assign w_wb_rd   = w_l_xfer ? i_l_rd   : i_p_rd;
  assign w_wb_data = w_l_xfer ? i_l_data : i_p_data;

  // Reset to L so that P wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= WB_L;
    end else if (w_p_xfer) begin
      r_last <= WB_P;
    end else if (w_l_xfer) begin
      r_last <= WB_L;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_xfer && (w_wb_rd != '0);
      if (w_xfer) begin
        r_rf_waddr <= w_wb_rd;
        r_rf_wdata <= w_wb_data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (w_sb_set),
    .i_set_addr (i_iss_rd),
    .i_clr      (w_l_xfer),
    .i_clr_addr (i_l_rd),
    .i_rs1      (i_iss_rs1),
    .i_rs2      (i_iss_rs2),
    .i_rd       (i_iss_rd),
    .o_busy_rs1 (w_busy_rs1),
    .o_busy_rs2 (w_busy_rs2),
    .o_busy_rd  (w_busy_rd)
  );

  // The registered write commits one edge later, so a reader in this cycle
  // would still see the old register file contents.
  assign w_inflight = r_rf_we && (r_rf_waddr != '0) &&
                      ((r_rf_waddr == i_iss_rs1) || (r_rf_waddr == i_iss_rs2));

  assign w_hazard = w_busy_rs1 | w_busy_rs2 | w_busy_rd | w_inflight;

  assign w_sb_set = i_iss_valid & i_iss_long & ~w_hazard & (i_iss_rd != '0);

  assign o_iss_hazard = w_hazard;
  assign o_p_ready    = w_p_ready;
  assign o_l_ready    = w_l_ready;
  assign o_rf_we      = r_rf_we;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios followed by randomized traffic, all
// checked against a behavioural model of the arbiter and scoreboard.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic            clk;
  logic            rst;
  logic            iss_valid;
  logic            iss_long;
  logic [AW-1:0]   iss_rs1;
  logic [AW-1:0]   iss_rs2;
  logic [AW-1:0]   iss_rd;
  logic            iss_hazard;
  logic            p_valid;
  logic            p_ready;
  logic [AW-1:0]   p_rd;
  logic [XLEN-1:0] p_data;
  logic            l_valid;
  logic            l_ready;
  logic [AW-1:0]   l_rd;
  logic [XLEN-1:0] l_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  rf_wb_arbiter u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_iss_valid  (iss_valid),
    .i_iss_long   (iss_long),
    .i_iss_rs1    (iss_rs1),
    .i_iss_rs2    (iss_rs2),
    .i_iss_rd     (iss_rd),
    .o_iss_hazard (iss_hazard),
    .i_p_valid    (p_valid),
    .o_p_ready    (p_ready),
    .i_p_rd       (p_rd),
    .i_p_data     (p_data),
    .i_l_valid    (l_valid),
    .o_l_ready    (l_ready),
    .i_l_rd       (l_rd),
    .i_l_data     (l_data),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state
  bit              m_busy [NREG];
  int              m_last_was_l;   // 1: L won the most recent transfer
  bit              m_we;
  int              m_waddr;
  logic [XLEN-1:0] m_wdata;
  bit              g_p;            // model granted P in the last cycle
  bit              g_l;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_last_was_l = 1;
    m_we         = 1'b0;
    m_waddr      = 0;
    m_wdata      = '0;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_long = 1'b0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    p_valid = 1'b0; p_rd = '0; p_data = '0;
    l_valid = 1'b0; l_rd = '0; l_data = '0;
  endtask

  // Check one cycle at the falling edge, then advance the model across the
  // rising edge. Returns at rising edge + 1.
  task automatic cycle();
    bit e_pr, e_lr, e_haz, set;
    @(negedge clk);
    if (p_valid && l_valid) begin
      e_pr = (m_last_was_l == 1);
      e_lr = !e_pr;
    end else begin
      e_pr = p_valid;
      e_lr = l_valid;
    end
    e_haz = m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd] ||
            (m_we && m_waddr != 0 && (m_waddr == int'(iss_rs1) || m_waddr == int'(iss_rs2)));
    check_eq("p_ready", 64'(p_ready), 64'(e_pr));
    check_eq("l_ready", 64'(l_ready), 64'(e_lr));
    check_eq("iss_hazard", 64'(iss_hazard), 64'(e_haz));
    check_eq("rf_we", 64'(rf_we), 64'(m_we));
    check_eq("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check_eq("rf_wdata", rf_wdata, m_wdata);
    g_p = p_valid && e_pr;
    g_l = l_valid && e_lr;
    set = iss_valid && iss_long && !e_haz && iss_rd != 0;
    if (g_l) m_busy[l_rd] = 1'b0;
    if (set) m_busy[iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (g_p) begin
      m_last_was_l = 0; m_we = (p_rd != 0); m_waddr = int'(p_rd); m_wdata = p_data;
    end else if (g_l) begin
      m_last_was_l = 1; m_we = (l_rd != 0); m_waddr = int'(l_rd); m_wdata = l_data;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and check that every register clears immediately.
  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check_eq("rst_rf_wdata", rf_wdata, 64'd0);
    check_eq("rst_p_ready", 64'(p_ready), 64'd0);
    check_eq("rst_l_ready", 64'(l_ready), 64'd0);
    for (int i = 0; i < NREG; i++) begin
      iss_rs1 = AW'(i);
      #1 check_eq("rst_busy_clear", 64'(iss_hazard), 64'd0);
    end
    iss_rs1 = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int cont_exp [4] = '{3, 4, 3, 4};

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    g_p   = 1'b0;
    g_l   = 1'b0;
    idle();
    model_reset();
    #1;
    do_reset();

    // Contention right after reset: P wins the first tie, then alternation.
    p_valid = 1'b1; p_rd = 5'd3; p_data = 64'h33;
    l_valid = 1'b1; l_rd = 5'd4; l_data = 64'h44;
    #1 check_eq("first_tie_p_ready", 64'(p_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("cont_waddr", 64'(rf_waddr), 64'(cont_exp[k]));
    end
    p_valid = 1'b0; l_valid = 1'b0;
    cycle();

    // Scoreboard: long issue to x7, stall, L writeback, in-flight, release.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0; iss_rs1 = 5'd7;
    #1 check_eq("sb_busy7_hazard", 64'(iss_hazard), 64'd1);
    cycle();
    l_valid = 1'b1; l_rd = 5'd7; l_data = 64'hDEAD;
    cycle();
    l_valid = 1'b0;
    #1 check_eq("sb_inflight_hazard", 64'(iss_hazard), 64'd1);
    check_eq("sb_wdata", rf_wdata, 64'hDEAD);
    cycle();
    #1 check_eq("sb_hazard_drop", 64'(iss_hazard), 64'd0);

    // x0: consumed but never written, never marked busy.
    iss_rs1 = '0;
    p_valid = 1'b1; p_rd = '0; p_data = 64'h123;
    #1 check_eq("x0_p_ready", 64'(p_ready), 64'd1);
    cycle();
    p_valid = 1'b0;
    check_eq("x0_no_write", 64'(rf_we), 64'd0);
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = '0;
    cycle();
    iss_valid = 1'b0; iss_long = 1'b0;
    #1 check_eq("x0_no_hazard", 64'(iss_hazard), 64'd0);
    cycle();

    // Simultaneous clear and set of x9: set wins.
    l_valid = 1'b1; l_rd = 5'd9; l_data = 64'h99;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; iss_rs1 = '0; iss_rs2 = '0;
    #1 check_eq("setclr_no_hazard", 64'(iss_hazard), 64'd0);
    cycle();
    l_valid = 1'b0; iss_valid = 1'b0; iss_long = 1'b0; iss_rd = '0; iss_rs1 = 5'd9;
    cycle();
    // In-flight write has retired, so only the busy bit can raise the hazard.
    check_eq("setclr_busy9", 64'(iss_hazard), 64'd1);
    iss_rs1 = '0;
    l_valid = 1'b1; l_rd = 5'd9;
    cycle();
    l_valid = 1'b0;
    cycle();

    // Reset mid-stream with busy[5] set and a write in flight.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd5;
    p_valid = 1'b1; p_rd = 5'd6; p_data = 64'h66;
    cycle();
    idle();
    iss_rs1 = 5'd5;
    #1 check_eq("pre_rst_we", 64'(rf_we), 64'd1);
    check_eq("pre_rst_busy5", 64'(iss_hazard), 64'd1);
    do_reset();
    for (int k = 0; k < 3; k++) cycle();
    check_eq("post_rst_no_stale", 64'(rf_we), 64'd0);

    // Randomized traffic; requesters hold their request until it is taken.
    for (int k = 0; k < 800; k++) begin
      if (!p_valid || g_p) begin
        p_valid = 1'($urandom_range(0, 1));
        p_rd    = AW'($urandom_range(0, 15));
        p_data  = {$urandom, $urandom};
      end
      if (!l_valid || g_l) begin
        l_valid = 1'($urandom_range(0, 1));
        l_rd    = AW'($urandom_range(0, 15));
        l_data  = {$urandom, $urandom};
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = 1'($urandom_range(0, 1));
      iss_rs1   = AW'($urandom_range(0, 15));
      iss_rs2   = AW'($urandom_range(0, 15));
      iss_rd    = AW'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port between two writeback requesters: the in-order pipeline writeback stage (port P) and the long-latency unit (port L, mul/div/load miss). The block also keeps a per-register busy scoreboard so decode can stall on registers with an outstanding long-latency result or an in-flight write. It sits between the writeback sources and the register file write port (`we`/`waddr`/`wdata`). Decode queries it every cycle.

## Interface
- `XLEN`, 64: data width.
- `NREG`, 32: architectural register count; address width `AW = $clog2(NREG)` = 5.

- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `iss_valid` in 1: decode issues an instruction this cycle.
- `iss_long` in 1: the issued instruction completes through port L.
- `iss_rs1`, `iss_rs2`, `iss_rd` in AW: source and destination of the instruction in decode.
- `iss_hazard` out 1: combinational stall request to decode.
- `p_valid` in 1, `p_ready` out 1, `p_rd` in AW, `p_data` in XLEN: pipeline writeback request.
- `l_valid` in 1, `l_ready` out 1, `l_rd` in AW, `l_data` in XLEN: long-unit writeback request.
- `rf_we` out 1, `rf_waddr` out AW, `rf_wdata` out XLEN: register file write port.

## Operation
- **Handshake.** A transfer on port X happens when `X_valid & X_ready` at a rising edge. After `X_valid` rises, the requester holds `X_valid`, `X_rd` and `X_data` stable until the transfer.
- **Arbitration.** Combinational, round-robin, driven by the 1-bit `last` register (0 = P granted last, 1 = L).
  - Only one port valid: that port gets ready.
  - Both valid: the port not equal to `last` gets ready.
  - `last` updates only on a transfer.
  - `p_ready` and `l_ready` are never both 1.
- **Output register.** On a transfer the block registers the write:
  - `rf_we` = (rd != 0)
  - `rf_waddr` = rd
  - `rf_wdata` = data
  - With no transfer, `rf_we` goes to 0. `rf_waddr` and `rf_wdata` hold their values.
  - rd = 0 is accepted and consumed but never written.
- **Scoreboard.** One `busy` bit per register, with `busy[0]` hardwired to 0.
  - Set on `iss_valid & iss_long & ~iss_hazard & iss_rd != 0`.
  - Cleared on a port L transfer, for `l_rd`.
  - Set and clear of the same register in the same cycle: set wins.
  - Port P transfers never touch `busy`.
- **Hazard.** `iss_hazard` = `busy[rs1] | busy[rs2] | busy[rd]` (rd is checked for WAW), OR'd with `rf_we & rf_waddr != 0 & rf_waddr ∈ {rs1, rs2}` (write in flight, not yet visible to a read).
- **Misuse.** `iss_valid` while `iss_hazard` = 1 does not set `busy`.

## Timing
- **Reset** (asynchronous, immediate):
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0
  - `busy` = all 0
  - `last` = 1, so P wins the first tie
  - `p_ready` and `l_ready` follow the combinational rules: 0 unless that port is valid
- **Latency.**
  - Transfer at edge N → `rf_we` high during cycle N..N+1 → register file commits at edge N+1.
  - `busy` clears at edge N.
  - The in-flight term keeps `iss_hazard` high for that register through cycle N..N+1.
- **Throughput.** One transfer per cycle. Back-to-back contention alternates P, L, P, L.
- **Reset mid-operation.** Pending requests are dropped, `busy` clears, and any in-flight write is lost. Requesters must also be reset.

## Structure
- Package `rf_pkg`:
  - `XLEN`, `NREG`, `AW`
  - enum `wb_src_e` {`WB_P` = 0, `WB_L` = 1}, used for `last`
- Sub-module `rf_scoreboard`: `busy` array, set/clear logic with set priority, combinational lookup of three addresses.
- Top level: arbiter, `last` register, output register, in-flight compare.

## Test plan
- **Reset values.** Assert `rst` mid-cycle → `rf_we` = 0, `rf_waddr` = 0, `busy` all 0 immediately. Then `p_valid` & `l_valid` together → `p_ready` = 1 on the first cycle.
- **Contention.** `p_valid` and `l_valid` held high for 4 cycles with rd 3 and 4 → grants P, L, P, L. `rf_waddr` sequence is 3, 4, 3, 4, each one cycle after its grant.
- **Scoreboard.**
  - Issue long with rd = 7 → `busy[7]`.
  - Decode with rs1 = 7 → `iss_hazard` = 1.
  - L transfer with `l_rd` = 7, `l_data` = 0xDEAD → `iss_hazard` stays 1 for one more cycle (in flight), then drops. `rf_wdata` = 0xDEAD.
- **x0 handling.** P transfer with rd = 0 → `p_ready` = 1 and `rf_we` = 0. Issue long with rd = 0 → `busy` unchanged and no hazard.
- **Simultaneous set/clear.** In the same cycle, L transfer clears rd = 9 and a long issue sets rd = 9 (with rs1/rs2/rd hazard forced 0 by the preceding clear) → `busy[9]` = 1 afterwards.
- **Reset mid-stream.** Assert `rst` with `busy[5]` set and `rf_we` = 1 → both clear immediately. After release, no stale write occurs.
